// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with stall, flush and T_new countdown.
// Optional STAGE_PERF_CNT_EN adds saturating stall/flush counters.
module pipe_stage_reg #(
  parameter int DATA_W           = 96,
  parameter int TNEW_W           = 2,
  parameter int DEC_TNEW         = 1,
  parameter int KEEP_PC_ON_FLUSH = 1,
  parameter int CNT_W            = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [31:0]       in_pc,
  input  logic [4:0]        in_a3,
  input  logic              in_regwrite,
  input  logic [TNEW_W-1:0] in_tnew,
  input  logic [DATA_W-1:0] in_payload,
  output logic              out_valid,
  output logic [31:0]       out_pc,
  output logic [31:0]       out_pc8,
  output logic [4:0]        out_a3,
  output logic              out_regwrite,
  output logic [TNEW_W-1:0] out_tnew,
  output logic [DATA_W-1:0] out_payload,
  output logic              out_bubble
`ifdef STAGE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`endif
);

  logic              valid_q, valid_d;
  logic [31:0]       pc_q, pc_d;
  logic [4:0]        a3_q, a3_d;
  logic              regwrite_q, regwrite_d;
  logic [TNEW_W-1:0] tnew_q, tnew_d;
  logic [DATA_W-1:0] payload_q, payload_d;
  logic              bubble_q, bubble_d;
  logic [TNEW_W-1:0] tnew_ld;

  // Remaining latency shrinks by one per stage advance, floored at zero.
  always_comb begin
    tnew_ld = '0;
    if (in_valid) begin
      if (DEC_TNEW != 0) begin
        if (in_tnew != '0) begin
          tnew_ld = in_tnew - TNEW_W'(1);
        end
      end else begin
        tnew_ld = in_tnew;
      end
    end
  end

  always_comb begin
    valid_d    = valid_q;
    pc_d       = pc_q;
    a3_d       = a3_q;
    regwrite_d = regwrite_q;
    tnew_d     = tnew_q;
    payload_d  = payload_q;
    bubble_d   = bubble_q;
    if (reset) begin
      valid_d    = 1'b0;
      pc_d       = '0;
      a3_d       = '0;
      regwrite_d = 1'b0;
      tnew_d     = '0;
      payload_d  = '0;
      bubble_d   = 1'b1;
    end else if (flush) begin
      valid_d    = 1'b0;
      pc_d       = (KEEP_PC_ON_FLUSH != 0) ? in_pc : 32'd0;
      a3_d       = '0;
      regwrite_d = 1'b0;
      tnew_d     = '0;
      payload_d  = '0;
      bubble_d   = 1'b1;
    end else if (!stall) begin
      valid_d    = in_valid;
      pc_d       = in_pc;
      a3_d       = in_valid ? in_a3 : 5'd0;
      regwrite_d = in_valid & in_regwrite & (in_a3 != 5'd0);
      tnew_d     = tnew_ld;
      payload_d  = in_payload;
      bubble_d   = ~in_valid;
    end
  end

  always_ff @(posedge clk) begin
    valid_q    <= valid_d;
    pc_q       <= pc_d;
    a3_q       <= a3_d;
    regwrite_q <= regwrite_d;
    tnew_q     <= tnew_d;
    payload_q  <= payload_d;
    bubble_q   <= bubble_d;
  end

  assign out_valid    = valid_q;
  assign out_pc       = pc_q;
  assign out_pc8      = pc_q + 32'd8;
  assign out_a3       = a3_q;
  assign out_regwrite = regwrite_q;
  assign out_tnew     = tnew_q;
  assign out_payload  = payload_q;
  assign out_bubble   = bubble_q;

`ifdef STAGE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Counters stick at all-ones instead of wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (reset) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (stall && !flush && !(&stall_cnt_q)) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if (flush && !(&flush_cnt_q)) begin
        flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    stall_cnt_q <= stall_cnt_d;
    flush_cnt_q <= flush_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomized bench for pipe_stage_reg against a behavioural model.
// Define STAGE_PERF_CNT_EN to also cover the perf counters.
module tb_pipe_stage_reg;

  localparam int DATA_W = 96;
  localparam int TNEW_W = 2;
  localparam int CNT_W  = 4;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              stall;
  logic              flush;
  logic              in_valid;
  logic [31:0]       in_pc;
  logic [4:0]        in_a3;
  logic              in_regwrite;
  logic [TNEW_W-1:0] in_tnew;
  logic [DATA_W-1:0] in_payload;
  logic              out_valid;
  logic [31:0]       out_pc;
  logic [31:0]       out_pc8;
  logic [4:0]        out_a3;
  logic              out_regwrite;
  logic [TNEW_W-1:0] out_tnew;
  logic [DATA_W-1:0] out_payload;
  logic              out_bubble;
`ifdef STAGE_PERF_CNT_EN
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;
`endif

  pipe_stage_reg #(
    .DATA_W(DATA_W),
    .TNEW_W(TNEW_W),
    .DEC_TNEW(1),
    .KEEP_PC_ON_FLUSH(1),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .stall(stall),
    .flush(flush),
    .in_valid(in_valid),
    .in_pc(in_pc),
    .in_a3(in_a3),
    .in_regwrite(in_regwrite),
    .in_tnew(in_tnew),
    .in_payload(in_payload),
    .out_valid(out_valid),
    .out_pc(out_pc),
    .out_pc8(out_pc8),
    .out_a3(out_a3),
    .out_regwrite(out_regwrite),
    .out_tnew(out_tnew),
    .out_payload(out_payload),
    .out_bubble(out_bubble)
`ifdef STAGE_PERF_CNT_EN
    ,
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference state, described as plain numbers.
  bit          m_valid;
  int unsigned m_pc;
  int unsigned m_a3;
  bit          m_rw;
  int unsigned m_tnew;
  logic [DATA_W-1:0] m_pl;
  bit          m_bub;
  int          m_scnt;
  int          m_fcnt;

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    if (reset) begin
      m_valid = 0; m_pc = 0; m_a3 = 0; m_rw = 0;
      m_tnew = 0; m_pl = '0; m_bub = 1;
      m_scnt = 0; m_fcnt = 0;
    end else begin
      if (flush) begin
        m_valid = 0; m_pc = in_pc; m_a3 = 0; m_rw = 0;
        m_tnew = 0; m_pl = '0; m_bub = 1;
        if (m_fcnt < CMAX) m_fcnt++;
      end else if (stall) begin
        if (m_scnt < CMAX) m_scnt++;
      end else begin
        m_valid = in_valid;
        m_pc    = in_pc;
        m_pl    = in_payload;
        m_bub   = !in_valid;
        m_a3    = in_valid ? int'(in_a3) : 0;
        m_rw    = in_valid && in_regwrite && (in_a3 != 0);
        if (!in_valid || in_tnew == 0) m_tnew = 0;
        else m_tnew = int'(in_tnew) - 1;
      end
    end
  endtask

  task automatic compare_all(input string t);
    int unsigned pc8;
    pc8 = m_pc + 32'd8;
    check({t, ".valid"}, 128'(out_valid), 128'(m_valid));
    check({t, ".pc"}, 128'(out_pc), 128'(m_pc));
    check({t, ".pc8"}, 128'(out_pc8), 128'(pc8));
    check({t, ".a3"}, 128'(out_a3), 128'(m_a3));
    check({t, ".rw"}, 128'(out_regwrite), 128'(m_rw));
    check({t, ".tnew"}, 128'(out_tnew), 128'(m_tnew));
    check({t, ".pl"}, 128'(out_payload), 128'(m_pl));
    check({t, ".bub"}, 128'(out_bubble), 128'(m_bub));
`ifdef STAGE_PERF_CNT_EN
    check({t, ".scnt"}, 128'(stall_cnt), 128'(m_scnt));
    check({t, ".fcnt"}, 128'(flush_cnt), 128'(m_fcnt));
`endif
  endtask

  task automatic step(input string t, input logic r, input logic st,
                      input logic fl, input logic v,
                      input logic [31:0] pc, input logic [4:0] a3,
                      input logic rw, input logic [1:0] tn,
                      input logic [95:0] pl);
    reset = r; stall = st; flush = fl;
    in_valid = v; in_pc = pc; in_a3 = a3;
    in_regwrite = rw; in_tnew = tn; in_payload = pl;
    @(posedge clk);
    model_edge();
    #1;
    compare_all(t);
  endtask

  initial begin
    reset = 1; stall = 0; flush = 0; in_valid = 0; in_pc = 0;
    in_a3 = 0; in_regwrite = 0; in_tnew = 0; in_payload = '0;

    step("rst0", 1, 0, 0, 1, 32'h1234, 5'd3, 1, 2'd3, 96'h55);
    step("rst1", 1, 0, 0, 1, 32'h1234, 5'd3, 1, 2'd3, 96'h55);
    check("rst.pc8", 128'(out_pc8), 128'h8);
    check("rst.bub", 128'(out_bubble), 128'h1);

    step("load", 0, 0, 0, 1, 32'h3000, 5'd5, 1, 2'd2, 96'hABC);
    check("load.tnew", 128'(out_tnew), 128'h1);
    check("load.pc8", 128'(out_pc8), 128'h3008);
    check("load.rw", 128'(out_regwrite), 128'h1);

    for (int i = 0; i < 3; i++)
      step("stall", 0, 1, 0, 1, 32'h4000, 5'd7, 1, 2'd3, 96'hDEF);
    check("stall.tnew", 128'(out_tnew), 128'h1);
    check("stall.pc", 128'(out_pc), 128'h3000);
`ifdef STAGE_PERF_CNT_EN
    check("stall.scnt", 128'(stall_cnt), 128'h3);
`endif

    step("sflush", 0, 1, 1, 1, 32'h3004, 5'd9, 1, 2'd3, 96'h777);
    check("sflush.pc", 128'(out_pc), 128'h3004);
    check("sflush.bub", 128'(out_bubble), 128'h1);
`ifdef STAGE_PERF_CNT_EN
    check("sflush.fcnt", 128'(flush_cnt), 128'h1);
    check("sflush.scnt", 128'(stall_cnt), 128'h3);
`endif

    step("tn0", 0, 0, 0, 1, 32'h3008, 5'd4, 1, 2'd0, 96'h1);
    check("tn0.tnew", 128'(out_tnew), 128'h0);
    step("a30", 0, 0, 0, 1, 32'h300C, 5'd0, 1, 2'd3, 96'h2);
    check("a30.rw", 128'(out_regwrite), 128'h0);
    step("inv", 0, 0, 0, 0, 32'h3010, 5'd6, 1, 2'd3, 96'h3);
    step("wrap", 0, 0, 0, 1, 32'hFFFFFFFC, 5'd1, 1, 2'd1, 96'h4);
    check("wrap.pc8", 128'(out_pc8), 128'h4);

`ifdef STAGE_PERF_CNT_EN
    step("rstc", 1, 0, 0, 0, 0, 0, 0, 0, '0);
    for (int i = 0; i < 20; i++)
      step("sat", 0, 1, 0, 1, 32'h10, 5'd2, 1, 2'd1, 96'h9);
    check("sat.scnt", 128'(stall_cnt), 128'hF);
    step("rstc2", 1, 1, 1, 0, 0, 0, 0, 0, '0);
    check("rstc2.scnt", 128'(stall_cnt), 128'h0);
`endif

    for (int i = 0; i < 400; i++) begin
      logic [31:0] pc;
      pc = ($urandom_range(0, 15) == 0) ? 32'hFFFFFFFC : $urandom;
      step("rnd",
           $urandom_range(0, 29) == 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 9) == 0,
           $urandom_range(0, 3) != 0,
           pc,
           5'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(0, 31)),
           1'($urandom),
           2'($urandom),
           {$urandom, $urandom, $urandom});
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
